// File: rtl/noc_pkg.sv
// Shared packet layout helpers for the NoC request injector.
// Field positions are derived from the address and node-id widths.
package noc_pkg;

  localparam int unsigned MAX_PKT_W = 64;

  function automatic int unsigned addr_lsb(input int unsigned id_w);
    return 2 * id_w + 1;
  endfunction

  function automatic int unsigned src_lsb(input int unsigned id_w);
    return id_w + 1;
  endfunction

  function automatic int unsigned dest_lsb();
    return 1;
  endfunction

  // Upper ID_W bits of the register index select the owning node.
  function automatic logic [31:0] dest_of(input logic [31:0] addr,
                                          input int unsigned addr_w,
                                          input int unsigned id_w);
    logic [31:0] mask;
    mask = (32'd1 << id_w) - 32'd1;
    return (addr >> (addr_w - id_w)) & mask;
  endfunction

  function automatic logic [MAX_PKT_W-1:0] pack_req(input logic [31:0] addr,
                                                    input logic [31:0] src,
                                                    input logic [31:0] dest,
                                                    input int unsigned id_w);
    logic [31:0]          mask;
    logic [MAX_PKT_W-1:0] pkt;
    mask = (32'd1 << id_w) - 32'd1;
    pkt  = {MAX_PKT_W{1'b0}};
    pkt  = pkt | (MAX_PKT_W'(addr) << addr_lsb(id_w));
    pkt  = pkt | (MAX_PKT_W'(src & mask) << src_lsb(id_w));
    pkt  = pkt | (MAX_PKT_W'(dest & mask) << dest_lsb());
    pkt  = pkt | MAX_PKT_W'(1);
    return pkt;
  endfunction

endpackage

// File: rtl/noc_req_fifo.sv
// Request FIFO: DEPTH entries of packet payload (valid bit implied), head
// is always visible; push/pop are ignored when full/empty respectively.
module noc_req_fifo #(
  parameter int unsigned W     = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic [W-1:0]               i_din,
  input  logic                       i_pop,
  output logic [W-1:0]               o_head,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push & (r_count != FULL_CNT);
  assign w_pop  = i_pop & (r_count != {CNT_W{1'b0}});

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/noc_request_injector.sv
// Register-read request injector: decodes destination, queues requests and
// issues packets to the router under the full/almost_full write rule.
module noc_request_injector
  import noc_pkg::*;
#(
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned NUM_NODES  = 4,
  parameter int unsigned ID_W       = $clog2(NUM_NODES),
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DROP_CNT_W = 8,
  parameter int unsigned WIDTH      = ADDR_W + 2 * ID_W + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ID_W-1:0]            id,
  input  logic                       req_valid,
  input  logic [ADDR_W-1:0]          req_addr,
  output logic                       req_ready,
  input  logic                       full,
  input  logic                       almost_full,
  output logic [WIDTH-1:0]           dataOut,
  output logic                       write,
  output logic [$clog2(DEPTH):0]     pending,
  output logic                       overflow,
  output logic [DROP_CNT_W-1:0]      drop_count
);

  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
  localparam int unsigned ENTRY_W = WIDTH - 1;
  localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(DEPTH);
  localparam logic [DROP_CNT_W-1:0] DROP_MAX = {DROP_CNT_W{1'b1}};

  logic [ENTRY_W-1:0]    w_entry;
  logic [ENTRY_W-1:0]    w_head;
  logic [CNT_W-1:0]      w_count;
  logic                  w_req_ready;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_send_ok;
  logic                  w_pop;
  logic                  r_write;
  logic [WIDTH-1:0]      r_data_out;
  logic                  r_overflow;
  logic [DROP_CNT_W-1:0] r_drop_count;

  // Packet is built (src/dest captured) at enqueue; the constant valid bit is not stored.
  assign w_entry = ENTRY_W'(pack_req(32'(req_addr), 32'(id),
                                     dest_of(32'(req_addr), ADDR_W, ID_W),
                                     ID_W) >> 1);

  assign w_req_ready = (w_count != FULL_CNT);
  assign w_push      = req_valid & w_req_ready;
  assign w_drop      = req_valid & ~w_req_ready;
  assign w_send_ok   = (r_write & ~almost_full) | (~r_write & ~full);
  assign w_pop       = (w_count != {CNT_W{1'b0}}) & w_send_ok;

  noc_req_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_din   (w_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // Issue register: dataOut holds its last packet while write is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_write    <= 1'b0;
      r_data_out <= {WIDTH{1'b0}};
    end else if (w_pop) begin
      r_write    <= 1'b1;
      r_data_out <= {w_head, 1'b1};
    end else begin
      r_write    <= 1'b0;
    end
  end

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow   <= 1'b0;
      r_drop_count <= {DROP_CNT_W{1'b0}};
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_count != DROP_MAX) r_drop_count <= r_drop_count + DROP_CNT_W'(1);
    end
  end

  assign req_ready  = w_req_ready;
  assign pending    = w_count;
  assign write      = r_write;
  assign dataOut    = r_data_out;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_noc_request_injector.sv
// Scoreboard bench for noc_request_injector: a queue-level reference model
// predicts packets and occupancy; a monitor checks every issued packet.
module tb_noc_request_injector;

  localparam int ADDR_W     = 6;
  localparam int NUM_NODES  = 4;
  localparam int ID_W       = 2;
  localparam int DEPTH      = 4;
  localparam int DROP_CNT_W = 8;
  localparam int WIDTH      = ADDR_W + 2 * ID_W + 1;
  localparam int DROP_MAX   = (1 << DROP_CNT_W) - 1;

  logic                    clk;
  logic                    reset;
  logic [ID_W-1:0]         id;
  logic                    req_valid;
  logic [ADDR_W-1:0]       req_addr;
  logic                    req_ready;
  logic                    full;
  logic                    almost_full;
  logic [WIDTH-1:0]        dataOut;
  logic                    write;
  logic [$clog2(DEPTH):0]  pending;
  logic                    overflow;
  logic [DROP_CNT_W-1:0]   drop_count;

  noc_request_injector dut (
    .clk         (clk),
    .reset       (reset),
    .id          (id),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_ready   (req_ready),
    .full        (full),
    .almost_full (almost_full),
    .dataOut     (dataOut),
    .write       (write),
    .pending     (pending),
    .overflow    (overflow),
    .drop_count  (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model state
  logic [WIDTH-1:0] mq[$];      // queued packets
  logic [WIDTH-1:0] exp_q[$];   // packets expected on the NoC, in order
  logic [WIDTH-1:0] m_last;
  bit               m_write;
  bit               m_ovf;
  int               m_drop;

  function automatic logic [WIDTH-1:0] expect_pkt(input int addr, input int src);
    int regs_per_node;
    int v;
    regs_per_node = (1 << ADDR_W) / NUM_NODES;
    v = addr * (1 << (2 * ID_W + 1)) + src * (1 << (ID_W + 1))
        + (addr / regs_per_node) * 2 + 1;
    return WIDTH'(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    exp_q.delete();
    m_last  = '0;
    m_write = 1'b0;
    m_ovf   = 1'b0;
    m_drop  = 0;
  endtask

  // One clock: drive inputs after negedge, update model at posedge, check at next negedge.
  task automatic cycle(input bit v, input int addr, input bit f, input bit af);
    bit ok;
    bit acc;
    int a_id;
    req_valid   = v;
    req_addr    = ADDR_W'(addr);
    full        = f;
    almost_full = af;
    #1;
    chk("req_ready", 32'(req_ready), 32'(mq.size() != DEPTH));
    ok   = (m_write && !af) || (!m_write && !f);
    acc  = v && (mq.size() != DEPTH);
    a_id = int'(id);
    @(posedge clk);
    if (ok && mq.size() > 0) begin
      m_last  = mq.pop_front();
      exp_q.push_back(m_last);
      m_write = 1'b1;
    end else begin
      m_write = 1'b0;
    end
    if (acc) mq.push_back(expect_pkt(addr, a_id));
    else if (v) begin
      m_ovf = 1'b1;
      if (m_drop != DROP_MAX) m_drop++;
    end
    @(negedge clk);
    chk("write", 32'(write), 32'(m_write));
    chk("pending", 32'(pending), 32'(mq.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("drop_count", 32'(drop_count), 32'(m_drop));
    chk("dataOut_hold", 32'(dataOut), 32'(m_last));
  endtask

  // Asynchronous reset asserted between edges; outputs must clear immediately.
  task automatic async_reset();
    #2;
    reset     = 1'b1;
    req_valid = 1'b0;
    #1;
    model_clear();
    chk("rst_write", 32'(write), 32'(m_write));
    chk("rst_pending", 32'(pending), 32'(mq.size()));
    chk("rst_overflow", 32'(overflow), 32'(m_ovf));
    chk("rst_drop", 32'(drop_count), 32'(m_drop));
    chk("rst_dataOut", 32'(dataOut), 32'(m_last));
    chk("rst_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: every issued packet must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && write) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pkt_unexpected: got %0h expected none at %0t", dataOut, $time);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        if (dataOut !== e) begin
          n_fail++;
          $display("FAIL pkt: got %0h expected %0h at %0t", dataOut, e, $time);
        end
      end
    end
  end

  int dec_addrs [8] = '{0, 15, 16, 31, 32, 47, 48, 63};

  initial begin
    reset = 1'b1; id = '0; req_valid = 1'b0; req_addr = '0;
    full = 1'b0; almost_full = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    chk("reset_write", 32'(write), 32'd0);
    chk("reset_pending", 32'(pending), 32'd0);
    chk("reset_dataOut", 32'(dataOut), 32'd0);
    reset = 1'b0;

    // Single request: id=2, addr=37
    id = 2'd2;
    cycle(1'b1, 37, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 0, 1'b0, 1'b0);

    // Destination decode boundaries, back to back
    for (int i = 0; i < 8; i++) cycle(1'b1, dec_addrs[i], 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 0, 1'b0, 1'b0);

    // Backpressure: fill under full, drop a 5th, then drain
    id = 2'd1;
    for (int i = 0; i < 5; i++) cycle(1'b1, 10 + 13 * i, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 0, 1'b0, 1'b0);

    // almost_full while writing, and almost_full alone with write low
    id = 2'd3;
    for (int i = 0; i < 3; i++) cycle(1'b1, 20 + i, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b1);
    cycle(1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 0, 1'b0, 1'b0);

    // Simultaneous push/pop at pending=2
    id = 2'd0;
    cycle(1'b1, 5, 1'b1, 1'b0);
    cycle(1'b1, 55, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 6 * i, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 0, 1'b0, 1'b0);

    // Reset mid-operation with queued requests
    for (int i = 0; i < 3; i++) cycle(1'b1, 40 + i, 1'b1, 1'b0);
    async_reset();
    for (int i = 0; i < 4; i++) cycle(1'b0, 0, 1'b0, 1'b0);

    // Drop counter saturation
    for (int i = 0; i < DEPTH + DROP_MAX + 5; i++) cycle(1'b1, i % 64, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 0, 1'b0, 1'b0);
    async_reset();

    // Randomized traffic with changing id and backpressure
    for (int i = 0; i < 3000; i++) begin
      id = ID_W'($urandom_range(0, NUM_NODES - 1));
      cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 63)),
            $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
      if ($urandom_range(0, 299) == 0) async_reset();
    end
    for (int i = 0; i < 8; i++) cycle(1'b0, 0, 1'b0, 1'b0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
